// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the instruction run controller.
// Holds the run-state enum and the NOP / EBREAK encodings.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        WAIT_STEP,
        HALT
    } run_state_t;

    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/instr_run_controller.sv
// Fetches words from synchronous instruction memory and commits them one per two cycles.
// Optional macro EBREAK_HALT_EN: a fetched ebreak halts the run without being committed.
module instr_run_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             abort,
    input  logic [CNT_W-1:0] instr_count,
    output logic [AW-1:0]    imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instruction,
    output logic             instr_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] retired
);

    // pc carries one extra bit so the increment past the last word never wraps
    localparam logic [AW:0] PC_LAST = (AW+1)'(DEPTH - 1);

    run_state_t       state, state_nxt;
    logic [AW:0]      pc, pc_nxt, pc_inc;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic [CNT_W-1:0] retired_nxt, retired_inc;
    logic [AW-1:0]    addr_nxt;
    logic [31:0]      instr_nxt;
    logic             valid_nxt, busy_nxt, done_nxt;
    logic             is_ebreak;

    assign pc_inc      = pc + 1'b1;
    assign retired_inc = retired + 1'b1;

    always_comb begin
`ifdef EBREAK_HALT_EN
        is_ebreak = (imem_rdata == INSTR_EBREAK);
`else
        is_ebreak = 1'b0;
`endif
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        count_nxt   = count_q;
        retired_nxt = retired;
        addr_nxt    = imem_addr;
        instr_nxt   = INSTR_NOP;
        valid_nxt   = 1'b0;
        busy_nxt    = (state == FETCH) || (state == EXEC) || (state == WAIT_STEP);
        done_nxt    = done;

        unique case (state)
            IDLE, HALT: begin
                if (state == HALT) done_nxt = 1'b1;
                if (start) begin
                    count_nxt   = instr_count;
                    pc_nxt      = '0;
                    retired_nxt = '0;
                    done_nxt    = 1'b0;
                    addr_nxt    = '0;
                    state_nxt   = (instr_count == '0) ? HALT : FETCH;
                end
            end
            FETCH: begin
                state_nxt = abort ? HALT : EXEC;
            end
            EXEC: begin
                if (is_ebreak) begin
                    state_nxt = HALT;
                end else begin
                    instr_nxt   = imem_rdata;
                    valid_nxt   = 1'b1;
                    retired_nxt = retired_inc;
                    pc_nxt      = pc_inc;
                    // Address for the next FETCH is set up one cycle early to hide the read latency
                    addr_nxt    = pc_inc[AW-1:0];
                    if (abort || (retired_inc == count_q) || (pc == PC_LAST))
                        state_nxt = HALT;
                    else if (step_mode)
                        state_nxt = WAIT_STEP;
                    else
                        state_nxt = FETCH;
                end
            end
            WAIT_STEP: begin
                if (abort)
                    state_nxt = HALT;
                else if (step_req || !step_mode)
                    state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= '0;
            count_q     <= '0;
            retired     <= '0;
            imem_addr   <= '0;
            instruction <= INSTR_NOP;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            count_q     <= count_nxt;
            retired     <= retired_nxt;
            imem_addr   <= addr_nxt;
            instruction <= instr_nxt;
            instr_valid <= valid_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

endmodule
